uart_frame_tx: RTL

//  Parametrised successor to the FIFO -> out -> UART transmit path: buffered byte stream in, framed serial out.

---
 rtl/uart_frame_tx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - FIFO-buffered framed UART transmitter with CRC-8 trailer; UART_FRAME_PARITY_EN adds even parity
module uart_frame_tx #(
    parameter int         DEPTH     = 16,
    parameter int         FRAME_LEN = 4,
    parameter int         BAUD_DIV  = 434,
    parameter logic [7:0] CRC_POLY  = 8'h07,
    parameter logic [7:0] CRC_INIT  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             crc_out,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0] C_FRAME     = CW'(FRAME_LEN);
    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
`ifdef UART_FRAME_PARITY_EN
    localparam logic [2:0] S_PARITY   = 3'd4;
`endif
    localparam logic [2:0] S_STOP     = 3'd5;
    localparam logic [2:0] S_CRC_LOAD = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_in_ready;
    logic          r_overflow;
    logic          w_push;
    logic          w_pop;

    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_crc;
    logic [CW-1:0] r_bytes_left;
    logic          r_crc_phase;
    logic [7:0]    r_crc_out;
    logic          r_frame_done;
    logic          r_tx;
    logic          w_tx_next;
    logic          w_last_tick;
    logic          w_start_frame;
    logic [CW-1:0] w_frame_len;
    logic [7:0]    w_fifo_rdata;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ CRC_POLY) : (x << 1);
        end
        return x;
    endfunction

    assign w_push       = in_valid && r_in_ready;
    assign w_pop        = (r_state == S_LOAD);
    assign w_fifo_rdata = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // in_ready is registered from the next count, so a pop on a full FIFO frees a slot one cycle later
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != C_DEPTH);
            if (in_valid && !r_in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_last_tick   = (r_baud == C_BAUD_LAST);
    assign w_start_frame = (r_count >= C_FRAME) || (flush && (r_count != '0));
    assign w_frame_len   = (r_count >= C_FRAME) ? C_FRAME : r_count;

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shreg[r_bit_idx];
`ifdef UART_FRAME_PARITY_EN
            S_PARITY: w_tx_next = ^r_shreg;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_crc        <= '0;
            r_bytes_left <= '0;
            r_crc_phase  <= 1'b0;
            r_crc_out    <= '0;
            r_frame_done <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            r_frame_done <= 1'b0;
            r_tx         <= w_tx_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start_frame) begin
                        r_bytes_left <= w_frame_len;
                        r_crc        <= CRC_INIT;
                        r_crc_phase  <= 1'b0;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shreg      <= w_fifo_rdata;
                    r_crc        <= crc8_byte(r_crc, w_fifo_rdata);
                    r_bytes_left <= r_bytes_left - 1'b1;
                    r_baud       <= '0;
                    r_state      <= S_START;
                end
                S_START: begin
                    if (w_last_tick) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last_tick) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_FRAME_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_FRAME_PARITY_EN
                S_PARITY: begin
                    if (w_last_tick) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_last_tick) begin
                        r_baud <= '0;
                        if (r_crc_phase) begin
                            r_state <= S_DONE;
                        end else if (r_bytes_left != '0) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_CRC_LOAD;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_CRC_LOAD: begin
                    r_shreg     <= r_crc;
                    r_crc_phase <= 1'b1;
                    r_baud      <= '0;
                    r_state     <= S_START;
                end
                S_DONE: begin
                    r_crc_out    <= r_crc;
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign crc_out    = r_crc_out;
endmodule
